// File: rtl/atmospheric_light_inverse.sv
// Purpose: scaled reciprocal of atmospheric light, Ac_Inv = floor(OMEGA_Q16 / Ac) per channel, Q0.16.
// Latency: 48 cycles from accepted start to done (three 16-cycle restoring divisions, no bubbles).
// Backpressure: none; start is only honoured in IDLE, results held until the next done.
// Optional build macro AC_MIN_CLAMP_EN: clamp latched Ac to AC_MIN before dividing (div_zero tied low).

module atmospheric_light_inverse #(
    parameter logic [15:0] OMEGA_Q16 = 16'd61440,
    parameter logic [7:0]  AC_MIN    = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  A_R,
    input  logic [7:0]  A_G,
    input  logic [7:0]  A_B,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [15:0] Ac_Inv_R,
    output logic [15:0] Ac_Inv_G,
    output logic [15:0] Ac_Inv_B
);

`ifdef AC_MIN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Latched operands; the run never looks at A_* again after start.
    logic [7:0]  a_r_q, a_g_q, a_b_q;
    logic [1:0]  ch_q;
    logic [3:0]  bit_cnt_q;
    // Remainder is always below the 8-bit divisor, so its 9th bit only ever
    // exists transiently inside the trial value.
    logic [7:0]  rem_q;
    logic [15:0] quo_q;
    logic [15:0] sh_r_q, sh_g_q;
    logic        dz_acc_q;
    logic        div_zero_q;
    logic [15:0] inv_r_q, inv_g_q, inv_b_q;

    logic [7:0]  divisor;
    logic [8:0]  trial;
    logic        take_bit;
    logic [7:0]  rem_next;
    logic [15:0] quo_next;
    logic        div_is_zero;
    logic [15:0] chan_res;
    logic        last_bit;

    function automatic logic [7:0] clamp_ac(input logic [7:0] a);
        return (CLAMP_EN && (a < AC_MIN)) ? AC_MIN : a;
    endfunction

    // One restoring-division step for the channel currently selected.
    always_comb begin
        divisor = a_r_q;
        case (ch_q)
            2'd1:    divisor = a_g_q;
            2'd2:    divisor = a_b_q;
            default: divisor = a_r_q;
        endcase
        trial       = {rem_q, quo_q[15]};
        take_bit    = (trial >= {1'b0, divisor});
        // When the subtraction happens the result is < divisor, so 8 bits suffice.
        rem_next    = take_bit ? (trial[7:0] - divisor) : trial[7:0];
        quo_next    = {quo_q[14:0], take_bit};
        div_is_zero = !CLAMP_EN && (divisor == 8'd0);
        chan_res    = div_is_zero ? 16'hFFFF : quo_next;
        last_bit    = (bit_cnt_q == 4'd0);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: DIV runs until the last bit of the blue channel, DONE is a single cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DIV;
            DIV:     if (last_bit && (ch_q == 2'd2)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand latch, iterative divider, shadow registers and published results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r_q      <= 8'd0;
            a_g_q      <= 8'd0;
            a_b_q      <= 8'd0;
            ch_q       <= 2'd0;
            bit_cnt_q  <= 4'd0;
            rem_q      <= 8'd0;
            quo_q      <= 16'd0;
            sh_r_q     <= 16'd0;
            sh_g_q     <= 16'd0;
            dz_acc_q   <= 1'b0;
            div_zero_q <= 1'b0;
            inv_r_q    <= 16'd0;
            inv_g_q    <= 16'd0;
            inv_b_q    <= 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_r_q      <= clamp_ac(A_R);
                        a_g_q      <= clamp_ac(A_G);
                        a_b_q      <= clamp_ac(A_B);
                        ch_q       <= 2'd0;
                        bit_cnt_q  <= 4'd15;
                        rem_q      <= 8'd0;
                        quo_q      <= OMEGA_Q16;
                        dz_acc_q   <= 1'b0;
                        div_zero_q <= 1'b0;
                    end
                end
                DIV: begin
                    rem_q     <= rem_next;
                    quo_q     <= quo_next;
                    bit_cnt_q <= last_bit ? 4'd15 : (bit_cnt_q - 4'd1);
                    if (last_bit) begin
                        dz_acc_q <= dz_acc_q | div_is_zero;
                        rem_q    <= 8'd0;
                        quo_q    <= OMEGA_Q16;
                        ch_q     <= ch_q + 2'd1;
                        case (ch_q)
                            2'd0: sh_r_q <= chan_res;
                            2'd1: sh_g_q <= chan_res;
                            default: begin
                                // Blue finishes now: publish all three at once.
                                inv_r_q    <= sh_r_q;
                                inv_g_q    <= sh_g_q;
                                inv_b_q    <= chan_res;
                                div_zero_q <= dz_acc_q | div_is_zero;
                                ch_q       <= 2'd0;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q == DIV);
    assign done     = (state_q == DONE);
    assign div_zero = div_zero_q;
    assign Ac_Inv_R = inv_r_q;
    assign Ac_Inv_G = inv_g_q;
    assign Ac_Inv_B = inv_b_q;

endmodule

// File: tb/tb_atmospheric_light_inverse.sv
// Scoreboarded bench for atmospheric_light_inverse: directed boundary runs, protocol and reset cases, random runs.
// Expected results come from plain integer division of omega by the (optionally clamped) Ac.
// A monitor pops the expected record on every done pulse and checks values, latency and hold behaviour.

module tb_atmospheric_light_inverse;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  A_R, A_G, A_B;
    logic        busy, done, div_zero;
    logic [15:0] Ac_Inv_R, Ac_Inv_G, Ac_Inv_B;

    atmospheric_light_inverse dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A_R      (A_R),
        .A_G      (A_G),
        .A_B      (A_B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .Ac_Inv_R (Ac_Inv_R),
        .Ac_Inv_G (Ac_Inv_G),
        .Ac_Inv_B (Ac_Inv_B)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [15:0] held_r = 16'h0, held_g = 16'h0, held_b = 16'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: omega / Ac as integer division; Ac = 0 saturates to all ones.
    function automatic logic [15:0] model_inv(input logic [7:0] a);
        int unsigned av;
        av = a;
`ifdef AC_MIN_CLAMP_EN
        if (av < 16) av = 16;
`endif
        if (av == 0) return 16'hFFFF;
        return 16'(61440 / av);
    endfunction

    function automatic logic model_dz(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
`ifdef AC_MIN_CLAMP_EN
        return 1'b0;
`else
        return (r == 8'd0) || (g == 8'd0) || (b == 8'd0);
`endif
    endfunction

    // Drives a start pulse sampled at the next rising edge and records what must come out.
    task automatic start_run(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t e;
        A_R   = r;
        A_G   = g;
        A_B   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.r   = model_inv(r);
        e.g   = model_inv(g);
        e.b   = model_inv(b);
        e.dz  = model_dz(r, g, b);
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Waits (bounded) for done, checking busy along the way, then for the return to idle.
    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            chk("busy_in_run", {31'd0, busy}, 32'd1);
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_timeout: got no done within 60 cycles, required done");
        end else begin
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    // Monitor: compares published results against the scoreboard, and holding between runs.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with no run pending, required none");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("inv_r", {16'd0, Ac_Inv_R}, {16'd0, e.r});
                    chk("inv_g", {16'd0, Ac_Inv_G}, {16'd0, e.g});
                    chk("inv_b", {16'd0, Ac_Inv_B}, {16'd0, e.b});
                    chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    chk("latency", cyc - e.cyc, 32'd48);
                    held_r = e.r;
                    held_g = e.g;
                    held_b = e.b;
                end
            end else begin
                chk("hold_r", {16'd0, Ac_Inv_R}, {16'd0, held_r});
                chk("hold_g", {16'd0, Ac_Inv_G}, {16'd0, held_g});
                chk("hold_b", {16'd0, Ac_Inv_B}, {16'd0, held_b});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        A_R   = 8'd0;
        A_G   = 8'd0;
        A_B   = 8'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        chk("rst_r", {16'd0, Ac_Inv_R}, 32'd0);
        chk("rst_g", {16'd0, Ac_Inv_G}, 32'd0);
        chk("rst_b", {16'd0, Ac_Inv_B}, 32'd0);

        // Nominal and boundary divisors.
        start_run(8'd255, 8'd200, 8'd128);
        wait_idle();
        start_run(8'd1, 8'd0, 8'd255);
        wait_idle();
        start_run(8'd1, 8'd3, 8'd255);
        wait_idle();
        start_run(8'd0, 8'd15, 8'd16);
        wait_idle();

        // Protocol: extra start pulses and changing A_* during the run are ignored.
        @(negedge clk);
        start_run(8'd90, 8'd45, 8'd7);
        for (int k = 1; k <= 49; k++) begin
            start = (k == 5) || (k == 49);
            A_R   = 8'($urandom_range(0, 255));
            A_G   = 8'($urandom_range(0, 255));
            A_B   = 8'($urandom_range(0, 255));
            chk("busy_protocol", {31'd0, busy}, (k <= 48) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        // First edge back in IDLE: a new run must start here.
        start_run(8'd17, 8'd250, 8'd2);
        wait_idle();

        // Reset in the middle of a run: nothing is published.
        @(negedge clk);
        start_run(8'd200, 8'd100, 8'd50);
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        held_r = 16'h0;
        held_g = 16'h0;
        held_b = 16'h0;
        rst_n  = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_r", {16'd0, Ac_Inv_R}, 32'd0);
        chk("midrst_dz", {31'd0, div_zero}, 32'd0);
        repeat (60) @(negedge clk);
        start_run(8'd64, 8'd32, 8'd240);
        wait_idle();

        // Random runs, zero divisors included now and then.
        for (int i = 0; i < 20; i++) begin
            logic [7:0] r, g, b;
            r = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            g = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            @(negedge clk);
            start_run(r, g, b);
            wait_idle();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
